// File: rtl/voice_mixer_pwm.sv
// voice_mixer_pwm
//
// Mixes the signed amplitudes of several note voices into one sample per PWM
// period. The sample is scaled by a 4-bit volume, saturated, and played out
// through a single-pin PWM output with a double-buffered duty register.
//
// Optional feature: define MIXER_CLIP_STATS_EN to build the clipped-sample
// counter behind clip_count. Without it clip_count is tied to zero.
//
// Parameters
//   CLK_FREQ  system clock in Hz; sample rate is CLK_FREQ / 2**PWM_BITS
//   AM_WIDTH  width of each signed voice amplitude and of mix
//   VOICES    number of voice inputs (1..16)
//   PWM_BITS  PWM resolution, period is 2**PWM_BITS clocks (>= AM_WIDTH)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   am_bus       packed signed amplitudes, voice i at [i*AM_WIDTH +: AM_WIDTH]
//   voice_en     per-voice enable, 0 contributes nothing to the sum
//   volume       gain = (volume+1)/16, 15 is unity
//   pwm_out      registered PWM audio pin
//   mix          signed saturated mixed sample
//   clip         latest sample was clamped
//   sample_tick  one-cycle pulse when mix/clip/next duty update
//   clip_count   saturating count of clipped samples
module voice_mixer_pwm #(
  parameter int CLK_FREQ = 120_000_000,
  parameter int AM_WIDTH = 8,
  parameter int VOICES   = 4,
  parameter int PWM_BITS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [VOICES*AM_WIDTH-1:0]   am_bus,
  input  logic [VOICES-1:0]            voice_en,
  input  logic [3:0]                   volume,
  output logic                         pwm_out,
  output logic signed [AM_WIDTH-1:0]   mix,
  output logic                         clip,
  output logic                         sample_tick,
  output logic [15:0]                  clip_count
);

  // Accumulator has 4 guard bits so 16 full-scale voices cannot overflow.
  // The product adds 6 bits for the signed gain of 1..16.
  localparam int ACC_W  = AM_WIDTH + 4;
  localparam int PROD_W = ACC_W + 6;
  localparam int IDX_W  = (VOICES > 1) ? $clog2(VOICES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_SCALE = 2'd2;
  localparam logic [1:0] ST_SAT   = 2'd3;

  localparam logic [PWM_BITS-1:0] MIDSCALE = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((2**(AM_WIDTH-1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2**(AM_WIDTH-1)));

  logic [PWM_BITS-1:0]          cnt;
  logic [PWM_BITS-1:0]          duty_next;
  logic [PWM_BITS-1:0]          duty_active;
  logic [1:0]                   state;
  logic [IDX_W-1:0]             idx;
  logic [VOICES*AM_WIDTH-1:0]   am_snap;
  logic [VOICES-1:0]            en_snap;
  logic [3:0]                   vol_snap;
  logic signed [ACC_W-1:0]      acc;
  logic signed [PROD_W-1:0]     scaled;

  logic signed [AM_WIDTH-1:0]   voice_cur;
  logic signed [ACC_W-1:0]      voice_ext;
  logic signed [5:0]            gain;
  logic signed [PROD_W-1:0]     product;
  logic signed [AM_WIDTH-1:0]   sat_val;
  logic                         sat_clip;
  logic [AM_WIDTH-1:0]          offset_bin;
  logic [PWM_BITS-1:0]          duty_from_sample;

  // Current voice for the accumulate step, sign-extended, or zero if disabled.
  always_comb begin
    voice_cur = am_snap[idx*AM_WIDTH +: AM_WIDTH];
    voice_ext = '0;
    if (en_snap[idx]) begin
      voice_ext = {{(ACC_W-AM_WIDTH){voice_cur[AM_WIDTH-1]}}, voice_cur};
    end
  end

  // Gain is volume+1 carried as a positive signed value so the multiply
  // stays signed; the >>>4 in SCALE finishes the divide by 16.
  always_comb begin
    gain    = $signed({2'b00, vol_snap} + 6'd1);
    product = PROD_W'(acc) * PROD_W'(gain);
  end

  // Clamp the scaled sum to the signed AM_WIDTH range and convert the result
  // to an offset-binary duty: most negative maps to 0, midscale to half.
  always_comb begin
    sat_val  = scaled[AM_WIDTH-1:0];
    sat_clip = 1'b0;
    if (scaled > SAT_MAX) begin
      sat_val  = SAT_MAX[AM_WIDTH-1:0];
      sat_clip = 1'b1;
    end else if (scaled < SAT_MIN) begin
      sat_val  = SAT_MIN[AM_WIDTH-1:0];
      sat_clip = 1'b1;
    end
    offset_bin       = {~sat_val[AM_WIDTH-1], sat_val[AM_WIDTH-2:0]};
    duty_from_sample = PWM_BITS'(offset_bin) << (PWM_BITS - AM_WIDTH);
  end

  // Free-running period counter and PWM comparator. The active duty only
  // changes on the last count of a period so every period has a single
  // constant duty; the snapshot happens one edge later at count 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      duty_active <= MIDSCALE;
      pwm_out     <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      pwm_out <= (cnt < duty_active);
      if (cnt == '1) begin
        duty_active <= duty_next;
      end
    end
  end

  // Sample computation: snapshot at count 0, walk the voices one per clock,
  // scale, then saturate and publish. Finishes in VOICES+3 clocks, far
  // inside one PWM period, so it never overlaps the next snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      am_snap     <= '0;
      en_snap     <= '0;
      vol_snap    <= '0;
      acc         <= '0;
      scaled      <= '0;
      mix         <= '0;
      clip        <= 1'b0;
      sample_tick <= 1'b0;
      duty_next   <= MIDSCALE;
    end else begin
      sample_tick <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cnt == '0) begin
            am_snap  <= am_bus;
            en_snap  <= voice_en;
            vol_snap <= volume;
            acc      <= '0;
            idx      <= '0;
            state    <= ST_ACC;
          end
        end
        ST_ACC: begin
          acc <= acc + voice_ext;
          if (idx == IDX_W'(VOICES - 1)) begin
            state <= ST_SCALE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_SCALE: begin
          scaled <= product >>> 4;
          state  <= ST_SAT;
        end
        ST_SAT: begin
          mix         <= sat_val;
          clip        <= sat_clip;
          sample_tick <= 1'b1;
          duty_next   <= duty_from_sample;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MIXER_CLIP_STATS_EN
  // Count clipped samples as they are published, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count <= '0;
    end else if ((state == ST_SAT) && sat_clip && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`else
  assign clip_count = 16'd0;
`endif

endmodule
